// File: rtl/l1c_data_2way_pkg.sv
// l1c_pkg: shared types and helpers for the 2-way L1 data cache
package l1c_pkg;
    typedef enum logic [2:0] {
        CT_BYTE    = 3'b000,
        CT_HWORD   = 3'b001,
        CT_WORD    = 3'b010,
        CT_BYTE_U  = 3'b100,
        CT_HWORD_U = 3'b101
    } cache_type_e;

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_REFILL, S_UNC_RD, S_WRITE, S_DONE} state_e;

    function automatic logic is_uncached(input logic [31:0] addr, input logic [31:0] b0, input logic [31:0] m0,
                                         input logic [31:0] b1, input logic [31:0] m1);
        return ((addr & m0) == b0) || ((addr & m1) == b1);
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] t, input logic [1:0] a);
        return (t[1:0] == 2'b10) ? 4'hF : t[0] ? (a[1] ? 4'b1100 : 4'b0011) : (4'b0001 << a);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction
endpackage

// File: rtl/l1c_data_2way_if.sv
// l1c_data_2way_if: core-side and memory-side buses of the L1 data cache
interface l1c_core_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
    logic              core_req;
    logic              core_write;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_in;
    logic [2:0]        core_type;
    logic              flush;
    logic [DATA_W-1:0] core_out;
    logic              core_wait;
    modport master (output core_req, core_write, core_addr, core_in, core_type, flush,
                    input core_out, core_wait);
    modport slave (input core_req, core_write, core_addr, core_in, core_type, flush,
                   output core_out, core_wait);
endinterface

interface l1c_mem_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
    logic              D_rreq;
    logic              D_wreq;
    logic [ADDR_W-1:0] D_addr;
    logic [DATA_W-1:0] D_in;
    logic [2:0]        D_type;
    logic [3:0]        D_len;
    logic [DATA_W-1:0] D_out;
    logic              D_wait;
    modport master (output D_rreq, D_wreq, D_addr, D_in, D_type, D_len, input D_out, D_wait);
    modport slave (input D_rreq, D_wreq, D_addr, D_in, D_type, D_len, output D_out, D_wait);
endinterface

// File: rtl/l1c_data_2way_way_array.sv
// l1c_way_array: one cache way's data/tag/valid arrays with line fill and byte-enable word write
module l1c_way_array #(
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 64,
    parameter int TAG_W      = 22
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                i_flush,
    input  logic [$clog2(SETS)-1:0]             i_idx,
    input  logic [$clog2(LINE_WORDS)-1:0]       i_word,
    input  logic                                i_fill,
    input  logic [TAG_W-1:0]                    i_fill_tag,
    input  logic [LINE_WORDS-1:0][DATA_W-1:0]   i_fill_line,
    input  logic                                i_wr,
    input  logic [DATA_W/8-1:0]                 i_be,
    input  logic [DATA_W-1:0]                   i_wdata,
    output logic                                o_valid,
    output logic [TAG_W-1:0]                    o_tag,
    output logic [DATA_W-1:0]                   o_word
);
    logic [LINE_WORDS-1:0][DATA_W-1:0] r_data [SETS];
    logic [TAG_W-1:0]                  r_tag  [SETS];
    logic [SETS-1:0]                   r_valid;

    // valid bits: cleared by reset or flush, set only when a complete line lands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_valid <= '0;
        else if (i_flush) r_valid <= '0;
        else if (i_fill) r_valid[i_idx] <= 1'b1;
    end

    // line/tag storage: whole-line refill or byte-lane store update
    always_ff @(posedge clk) begin
        if (i_fill) begin
            r_data[i_idx] <= i_fill_line;
            r_tag[i_idx]  <= i_fill_tag;
        end else if (i_wr) begin
            for (int b = 0; b < DATA_W/8; b++)
                if (i_be[b]) r_data[i_idx][i_word][8*b +: 8] <= i_wdata[8*b +: 8];
        end
    end

    assign o_valid = r_valid[i_idx];
    assign o_tag   = r_tag[i_idx];
    assign o_word  = r_data[i_idx][i_word];
endmodule

// File: rtl/l1c_data_2way.sv
// l1c_data_2way: 2-way set-associative write-through L1 data cache with burst refill
module l1c_data_2way
    import l1c_pkg::*;
#(
    parameter int          ADDR_W     = 32,
    parameter int          DATA_W     = 32,
    parameter int          LINE_WORDS = 4,
    parameter int          SETS       = 64,
    parameter logic [31:0] UC0_BASE   = 32'h1000_0000,
    parameter logic [31:0] UC0_MASK   = 32'hFFFF_0000,
    parameter logic [31:0] UC1_BASE   = 32'h4000_0000,
    parameter logic [31:0] UC1_MASK   = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        rst,
    l1c_core_if.slave   core,
    l1c_mem_if.master   mem,
    output logic [31:0] o_perf_rhit,
    output logic [31:0] o_perf_rmiss,
    output logic [31:0] o_perf_whit,
    output logic [31:0] o_perf_wmiss
);
    localparam int BEAT_W = $clog2(LINE_WORDS);
    localparam int OFF_W  = BEAT_W + 2;
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
    localparam logic [BEAT_W-1:0] LAST = BEAT_W'(LINE_WORDS - 1);

    state_e                            r_state;
    logic [ADDR_W-1:0]                 r_addr;
    logic [DATA_W-1:0]                 r_wdata;
    logic [2:0]                        r_type;
    logic                              r_write;
    logic                              r_hit0;
    logic                              r_hit1;
    logic                              r_victim;
    logic [DATA_W-1:0]                 r_core_out;
    logic                              r_d_rreq;
    logic                              r_d_wreq;
    logic [ADDR_W-1:0]                 r_d_addr;
    logic [DATA_W-1:0]                 r_d_in;
    logic [2:0]                        r_d_type;
    logic [3:0]                        r_d_len;
    logic [BEAT_W-1:0]                 r_beat;
    logic [LINE_WORDS-1:0][DATA_W-1:0] r_line;
    logic [SETS-1:0]                   r_lru;
    logic [31:0]                       r_perf_rhit;
    logic [31:0]                       r_perf_rmiss;
    logic [31:0]                       r_perf_whit;
    logic [31:0]                       r_perf_wmiss;

    logic [IDX_W-1:0]                  w_idx;
    logic [BEAT_W-1:0]                 w_word;
    logic [TAG_W-1:0]                  w_tag;
    logic                              w_unc;
    logic                              w_v0, w_v1;
    logic [TAG_W-1:0]                  w_t0, w_t1;
    logic [DATA_W-1:0]                 w_d0, w_d1;
    logic                              w_hit0, w_hit1;
    logic                              w_victim;
    logic                              w_flush;
    logic                              w_fill;
    logic                              w_wr0, w_wr1;
    logic [3:0]                        w_be;
    logic [LINE_WORDS-1:0][DATA_W-1:0] w_fill_line;

    assign w_idx    = r_addr[OFF_W +: IDX_W];
    assign w_word   = r_addr[2 +: BEAT_W];
    assign w_tag    = r_addr[ADDR_W-1 -: TAG_W];
    assign w_unc    = is_uncached(32'(r_addr), UC0_BASE, UC0_MASK, UC1_BASE, UC1_MASK);
    assign w_hit0   = w_v0 && (w_t0 == w_tag) && !w_unc;
    assign w_hit1   = w_v1 && (w_t1 == w_tag) && !w_unc;
    assign w_victim = !w_v0 ? 1'b0 : !w_v1 ? 1'b1 : r_lru[w_idx];
    assign w_flush  = (r_state == S_IDLE) && !core.core_req && core.flush;
    assign w_fill   = (r_state == S_REFILL) && !mem.D_wait && (r_beat == LAST);
    assign w_wr0    = (r_state == S_WRITE) && r_d_wreq && r_hit0;
    assign w_wr1    = (r_state == S_WRITE) && r_d_wreq && r_hit1;
    assign w_be     = byte_en(r_type, r_addr[1:0]);

    // completed line: buffered beats plus the final beat arriving this cycle
    always_comb begin
        w_fill_line       = r_line;
        w_fill_line[LAST] = mem.D_out;
    end

    l1c_way_array #(.DATA_W(DATA_W), .LINE_WORDS(LINE_WORDS), .SETS(SETS), .TAG_W(TAG_W)) u_way0 (
        .clk(clk), .rst(rst), .i_flush(w_flush), .i_idx(w_idx), .i_word(w_word),
        .i_fill(w_fill && !r_victim), .i_fill_tag(w_tag), .i_fill_line(w_fill_line),
        .i_wr(w_wr0), .i_be(w_be), .i_wdata(r_wdata),
        .o_valid(w_v0), .o_tag(w_t0), .o_word(w_d0)
    );

    l1c_way_array #(.DATA_W(DATA_W), .LINE_WORDS(LINE_WORDS), .SETS(SETS), .TAG_W(TAG_W)) u_way1 (
        .clk(clk), .rst(rst), .i_flush(w_flush), .i_idx(w_idx), .i_word(w_word),
        .i_fill(w_fill && r_victim), .i_fill_tag(w_tag), .i_fill_line(w_fill_line),
        .i_wr(w_wr1), .i_be(w_be), .i_wdata(r_wdata),
        .o_valid(w_v1), .o_tag(w_t1), .o_word(w_d1)
    );

    // main controller: request latch, lookup, refill/uncached/write transactions, LRU and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_type       <= CT_WORD;
            r_write      <= 1'b0;
            r_hit0       <= 1'b0;
            r_hit1       <= 1'b0;
            r_victim     <= 1'b0;
            r_core_out   <= '0;
            r_d_rreq     <= 1'b0;
            r_d_wreq     <= 1'b0;
            r_d_addr     <= '0;
            r_d_in       <= '0;
            r_d_type     <= CT_WORD;
            r_d_len      <= '0;
            r_beat       <= '0;
            r_line       <= '0;
            r_lru        <= '0;
            r_perf_rhit  <= '0;
            r_perf_rmiss <= '0;
            r_perf_whit  <= '0;
            r_perf_wmiss <= '0;
        end else begin
            r_d_rreq <= 1'b0;
            r_d_wreq <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (core.core_req) begin
                        r_addr  <= core.core_addr;
                        r_wdata <= core.core_in;
                        r_type  <= core.core_type;
                        r_write <= core.core_write;
                        r_state <= S_LOOKUP;
                    end else if (core.flush) begin
                        r_lru <= '0;
                    end
                end
                S_LOOKUP: begin
                    r_hit0 <= w_hit0;
                    r_hit1 <= w_hit1;
                    if (r_write) begin
                        r_d_wreq <= 1'b1;
                        r_d_addr <= r_addr;
                        r_d_in   <= r_wdata;
                        r_d_type <= r_type;
                        r_d_len  <= '0;
                        r_state  <= S_WRITE;
                    end else if (w_unc) begin
                        r_d_rreq <= 1'b1;
                        r_d_addr <= r_addr;
                        r_d_type <= CT_WORD;
                        r_d_len  <= '0;
                        r_state  <= S_UNC_RD;
                    end else if (w_hit0 || w_hit1) begin
                        r_core_out   <= w_hit1 ? w_d1 : w_d0;
                        r_lru[w_idx] <= !w_hit1;
                        r_perf_rhit  <= sat_inc(r_perf_rhit);
                        r_state      <= S_DONE;
                    end else begin
                        r_victim <= w_victim;
                        r_beat   <= '0;
                        r_d_rreq <= 1'b1;
                        r_d_addr <= {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        r_d_type <= CT_WORD;
                        r_d_len  <= 4'(LINE_WORDS - 1);
                        r_state  <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (!mem.D_wait) begin
                        r_line[r_beat] <= mem.D_out;
                        r_beat         <= r_beat + BEAT_W'(1);
                        if (r_beat == LAST) begin
                            r_core_out   <= w_fill_line[w_word];
                            r_lru[w_idx] <= !r_victim;
                            r_perf_rmiss <= sat_inc(r_perf_rmiss);
                            r_state      <= S_DONE;
                        end
                    end
                end
                S_UNC_RD: begin
                    if (!mem.D_wait) begin
                        r_core_out <= mem.D_out;
                        r_state    <= S_DONE;
                    end
                end
                S_WRITE: begin
                    if (r_d_wreq && (r_hit0 || r_hit1)) r_lru[w_idx] <= r_hit0;
                    if (!mem.D_wait) begin
                        if (!w_unc && (r_hit0 || r_hit1)) r_perf_whit <= sat_inc(r_perf_whit);
                        if (!w_unc && !(r_hit0 || r_hit1)) r_perf_wmiss <= sat_inc(r_perf_wmiss);
                        r_state <= S_DONE;
                    end
                end
                S_DONE: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign core.core_out  = r_core_out;
    assign core.core_wait = (r_state == S_IDLE) ? core.core_req : (r_state != S_DONE);
    assign mem.D_rreq     = r_d_rreq;
    assign mem.D_wreq     = r_d_wreq;
    assign mem.D_addr     = r_d_addr;
    assign mem.D_in       = r_d_in;
    assign mem.D_type     = r_d_type;
    assign mem.D_len      = r_d_len;
    assign o_perf_rhit    = r_perf_rhit;
    assign o_perf_rmiss   = r_perf_rmiss;
    assign o_perf_whit    = r_perf_whit;
    assign o_perf_wmiss   = r_perf_wmiss;
endmodule

// File: tb/tb_l1c_data_2way.sv
// tb_l1c_data_2way: scoreboard bench with a behavioural memory for the 2-way L1 data cache
module tb_l1c_data_2way;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    l1c_core_if core_bus ();
    l1c_mem_if  mem_bus ();
    logic [31:0] perf_rhit, perf_rmiss, perf_whit, perf_wmiss;

    l1c_data_2way dut (
        .clk(clk), .rst(rst), .core(core_bus), .mem(mem_bus),
        .o_perf_rhit(perf_rhit), .o_perf_rmiss(perf_rmiss),
        .o_perf_whit(perf_whit), .o_perf_wmiss(perf_wmiss)
    );

    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] mem_arr [logic [31:0]];
    logic [31:0] exp_q [$];
    int rd_cnt = 0;
    int wr_cnt = 0;
    int beat_k = -1;
    logic in_burst = 1'b0;
    logic [31:0] last_rd_addr = '0;
    logic [31:0] last_wr_addr = '0;
    logic [3:0]  last_rd_len  = '0;
    logic [2:0]  last_wr_type = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        return mem_arr.exists(a) ? mem_arr[a] : (a ^ 32'h5EED_0000);
    endfunction

    // memory: bursts with a gap before beat 1, writes complete in the pulse cycle
    initial begin : mem_model
        logic [31:0] a, wd, old;
        logic [3:0]  n, be;
        logic [2:0]  t;
        mem_bus.D_wait = 1'b1;
        mem_bus.D_out  = '0;
        forever begin
            @(negedge clk);
            mem_bus.D_wait = 1'b1;
            if (!rst && mem_bus.D_rreq) begin
                a = mem_bus.D_addr;
                n = mem_bus.D_len;
                rd_cnt++;
                last_rd_addr = a;
                last_rd_len  = n;
                in_burst     = 1'b1;
                for (int k = 0; k <= int'(n) && !rst; k++) begin
                    if (k == 1) begin
                        mem_bus.D_wait = 1'b1;
                        @(negedge clk);
                    end
                    mem_bus.D_wait = 1'b0;
                    mem_bus.D_out  = rd_word(a + 32'(4 * k));
                    beat_k = k;
                    @(negedge clk);
                end
                mem_bus.D_wait = 1'b1;
                in_burst = 1'b0;
                beat_k   = -1;
            end else if (!rst && mem_bus.D_wreq) begin
                a  = mem_bus.D_addr;
                wd = mem_bus.D_in;
                t  = mem_bus.D_type;
                wr_cnt++;
                last_wr_addr = a;
                last_wr_type = t;
                if (t == 3'b010) be = 4'hF;
                else if (t == 3'b001) be = a[1] ? 4'hC : 4'h3;
                else be = 4'h1 << a[1:0];
                old = rd_word({a[31:2], 2'b00});
                for (int b = 0; b < 4; b++)
                    if (be[b]) old[8*b +: 8] = wd[8*b +: 8];
                mem_arr[{a[31:2], 2'b00}] = old;
                mem_bus.D_wait = 1'b0;
            end
        end
    end

    task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [2:0] ty, output int cyc);
        logic [31:0] exp;
        core_bus.core_write = wr;
        core_bus.core_addr  = addr;
        core_bus.core_in    = data;
        core_bus.core_type  = ty;
        core_bus.core_req   = 1'b1;
        if (!wr) exp_q.push_back(rd_word({addr[31:2], 2'b00}));
        cyc = 1;
        do begin
            @(negedge clk);
            cyc++;
        end while (core_bus.core_wait && cyc < 300);
        if (core_bus.core_wait) check("timeout", 32'(core_bus.core_wait), 32'd0);
        core_bus.core_req = 1'b0;
        if (!wr) begin
            exp = exp_q.pop_front();
            check("load_data", core_bus.core_out, exp);
        end
        @(negedge clk);
    endtask

    task automatic load(input logic [31:0] addr, output int cyc);
        access(1'b0, addr, 32'h0, 3'b010, cyc);
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] ty);
        int cyc;
        access(1'b1, addr, data, ty, cyc);
    endtask

    initial begin : main
        int cyc, r0, w0;
        core_bus.core_req   = 1'b0;
        core_bus.core_write = 1'b0;
        core_bus.core_addr  = '0;
        core_bus.core_in    = '0;
        core_bus.core_type  = 3'b010;
        core_bus.flush      = 1'b0;
        mem_arr[32'h100] = 32'hA0;
        mem_arr[32'h104] = 32'hA1;
        mem_arr[32'h108] = 32'hA2;
        mem_arr[32'h10C] = 32'hA3;
        mem_arr[32'h1000_0004] = 32'h1234_5678;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_core_out", core_bus.core_out, 32'h0);
        check("rst_d_addr", mem_bus.D_addr, 32'h0);
        check("rst_d_type", 32'(mem_bus.D_type), 32'd2);
        check("rst_d_len", 32'(mem_bus.D_len), 32'd0);
        check("rst_rreq", 32'(mem_bus.D_rreq), 32'd0);
        check("rst_wait", 32'(core_bus.core_wait), 32'd0);
        check("rst_perf", perf_rhit | perf_rmiss | perf_whit | perf_wmiss, 32'h0);

        r0 = rd_cnt;
        load(32'h100, cyc);
        check("cold_rd_cnt", 32'(rd_cnt - r0), 32'd1);
        check("cold_addr", last_rd_addr, 32'h100);
        check("cold_len", 32'(last_rd_len), 32'd3);
        r0 = rd_cnt;
        load(32'h108, cyc);
        check("hit_word", core_bus.core_out, 32'hA2);
        check("hit_cycles", 32'(cyc), 32'd3);
        check("hit_no_rd", 32'(rd_cnt - r0), 32'd0);
        check("perf_rmiss1", perf_rmiss, 32'd1);
        check("perf_rhit1", perf_rhit, 32'd1);

        load(32'h500, cyc);
        load(32'h900, cyc);
        r0 = rd_cnt;
        load(32'h500, cyc);
        check("lru_keep_500", 32'(rd_cnt - r0), 32'd0);
        r0 = rd_cnt;
        load(32'h100, cyc);
        check("lru_evict_100", 32'(rd_cnt - r0), 32'd1);
        check("perf_rmiss4", perf_rmiss, 32'd4);
        check("perf_rhit2", perf_rhit, 32'd2);

        w0 = wr_cnt;
        r0 = rd_cnt;
        store(32'h101, 32'h0000_EE00, 3'b000);
        check("byte_wreq", 32'(wr_cnt - w0), 32'd1);
        check("byte_type", 32'(last_wr_type), 32'd0);
        check("byte_addr", last_wr_addr, 32'h101);
        load(32'h100, cyc);
        check("byte_merged", core_bus.core_out, 32'h0000_EEA0);
        check("byte_no_rd", 32'(rd_cnt - r0), 32'd0);
        check("perf_whit1", perf_whit, 32'd1);
        store(32'h10A, 32'hBBAA_0000, 3'b001);
        r0 = rd_cnt;
        load(32'h108, cyc);
        check("hword_merged", core_bus.core_out, 32'hBBAA_00A2);
        check("hword_no_rd", 32'(rd_cnt - r0), 32'd0);

        w0 = wr_cnt;
        r0 = rd_cnt;
        store(32'h200, 32'hDEAD_BEEF, 3'b010);
        check("wmiss_wreq", 32'(wr_cnt - w0), 32'd1);
        check("wmiss_no_rd", 32'(rd_cnt - r0), 32'd0);
        check("perf_wmiss1", perf_wmiss, 32'd1);
        load(32'h200, cyc);
        check("wmiss_no_alloc", 32'(rd_cnt - r0), 32'd1);
        check("wmiss_data", core_bus.core_out, 32'hDEAD_BEEF);

        r0 = rd_cnt;
        load(32'h1000_0004, cyc);
        check("unc_rd", 32'(rd_cnt - r0), 32'd1);
        check("unc_addr", last_rd_addr, 32'h1000_0004);
        check("unc_len", 32'(last_rd_len), 32'd0);
        check("unc_data", core_bus.core_out, 32'h1234_5678);
        r0 = rd_cnt;
        load(32'h1000_0004, cyc);
        check("unc_repeat", 32'(rd_cnt - r0), 32'd1);
        load(32'h4000_0010, cyc);
        check("unc1_len", 32'(last_rd_len), 32'd0);
        check("unc1_addr", last_rd_addr, 32'h4000_0010);
        store(32'h1000_0008, 32'h0BAD_F00D, 3'b010);
        check("unc_no_wmiss", perf_wmiss, 32'd1);
        check("unc_no_rmiss", perf_rmiss, 32'd5);
        check("unc_no_rhit", perf_rhit, 32'd4);

        load(32'h300, cyc);
        r0 = rd_cnt;
        load(32'h300, cyc);
        check("pre_flush_hit", 32'(rd_cnt - r0), 32'd0);
        core_bus.flush = 1'b1;
        @(negedge clk);
        core_bus.flush = 1'b0;
        r0 = rd_cnt;
        load(32'h300, cyc);
        check("flush_miss", 32'(rd_cnt - r0), 32'd1);

        core_bus.core_write = 1'b0;
        core_bus.core_addr  = 32'h700;
        core_bus.core_type  = 3'b010;
        core_bus.core_req   = 1'b1;
        cyc = 0;
        while (!(in_burst && beat_k >= 2) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_at_beat2", 32'(in_burst && beat_k >= 2), 32'd1);
        rst = 1'b1;
        core_bus.core_req = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mid_perf", perf_rmiss, 32'd0);
        check("rst_mid_rreq", 32'(mem_bus.D_rreq), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        r0 = rd_cnt;
        load(32'h700, cyc);
        check("rst_refill_rd", 32'(rd_cnt - r0), 32'd1);
        check("rst_refill_len", 32'(last_rd_len), 32'd3);
        r0 = rd_cnt;
        load(32'h704, cyc);
        check("rst_refill_hit", 32'(rd_cnt - r0), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/l1c_data_2way.md
Name: l1c_data_2way

Overview:
- Parametrised successor to the current single-way L1 data cache.
- 2-way set-associative, write-through, no-write-allocate. Per-set LRU bit, configurable line length and set count.
- Burst line refill, two configurable uncacheable windows, whole-cache flush, hit/miss performance counters.
- Sits between the CPU core data port and the CPU wrapper memory (AXI master) side. Storage is held in internal register arrays.

Parameters:
- ADDR_W, 32: address width.
- DATA_W, 32: word width (fixed 32 in this generation).
- LINE_WORDS, 4: words per line; power of two, 2..16.
- SETS, 64: sets per way; power of two, 2..256.
- UC0_BASE, 32'h1000_0000: base of uncacheable window 0.
- UC0_MASK, 32'hFFFF_0000: window 0 hit when (addr & UC0_MASK) == UC0_BASE.
- UC1_BASE, 32'h4000_0000: base of uncacheable window 1.
- UC1_MASK, 32'hFFFF_0000: mask of uncacheable window 1.

Ports:
- clk, in, 1: clock.
- rst, in, 1: reset, asynchronous, active-high.
- core_req, in, 1: access request, sampled in IDLE.
- core_write, in, 1: 1 = store, 0 = load.
- core_addr, in, ADDR_W: byte address.
- core_in, in, DATA_W: store data, already lane-aligned by the core.
- core_type, in, 3: BYTE=000, HWORD=001, WORD=010, BYTE_U=100, HWORD_U=101.
- flush, in, 1: invalidate all lines; honoured only in IDLE with core_req=0.
- core_out, out, DATA_W: full aligned load word; the core extracts and extends.
- core_wait, out, 1: stall to the core.
- D_rreq, out, 1: one-cycle read request pulse.
- D_wreq, out, 1: one-cycle write request pulse.
- D_addr, out, ADDR_W: memory address.
- D_in, out, DATA_W: write data.
- D_type, out, 3: core_type for writes, WORD for reads.
- D_len, out, 4: beats minus 1; LINE_WORDS-1 for a refill, 0 otherwise.
- D_out, in, DATA_W: read beat data.
- D_wait, in, 1: low for one cycle per returned read beat or write completion.
- perf_rhit, perf_rmiss, perf_whit, perf_wmiss, out, 32 each: saturating event counters.

Behaviour:
- Reset (async):
  - State IDLE; all valid and LRU bits cleared.
  - core_out, D_addr, D_in, perf counters = 0; D_rreq = D_wreq = 0; D_len = 0; D_type = WORD.
- Address split:
  - offset = addr[log2(LINE_WORDS)+1:0]
  - index = next log2(SETS) bits
  - tag = remaining upper bits
  - uncacheable = hit in window 0 or window 1.
- core_wait = core_req in IDLE, 0 in DONE, 1 in every other state.
- State machine:
  - IDLE:
    - core_req=1: latch addr/data/type/write and read both ways' tag/valid/data at index; go LOOKUP.
    - else if flush=1: clear all valid and LRU bits in one cycle; stay IDLE.
  - LOOKUP (hit = valid & tag match in way0 or way1; both ways matching is impossible by construction):
    - read hit: core_out <= hit word; LRU[index] <= other way; go DONE.
    - read miss, cacheable: go REFILL.
    - read, uncacheable: go UNC_RD; no array access.
    - write (any case): go WRITE.
  - REFILL:
    - First cycle: D_rreq=1, D_addr = line-aligned addr, D_len = LINE_WORDS-1.
    - Victim = first invalid way (way0 preferred), else way LRU[index].
    - Beat k (k-th D_wait=0 cycle) goes to word k of a line buffer.
    - After beat LINE_WORDS-1:
      - write the line, tag and valid into the victim way;
      - core_out <= requested word;
      - LRU[index] <= non-victim way;
      - go DONE.
    - Beats arriving early are not lost: cycle-by-cycle capture.
  - UNC_RD: D_rreq pulse, D_len = 0, exact D_addr; on D_wait=0, core_out <= D_out; go DONE. No fill.
  - WRITE:
    - D_wreq pulse, D_addr = exact addr, D_in = core_in, D_type = core_type.
    - On hit (cacheable only), the matching way is updated in the same cycle the pulse issues. Byte enables:
      - BYTE: lane addr[1:0].
      - HWORD: lanes {addr[1],0} and {addr[1],1}.
      - WORD: all lanes.
    - LRU is updated on a write hit. A miss does not allocate.
    - On D_wait=0: go DONE.
  - DONE: one cycle, core_wait=0; go IDLE.
- Request pulses are exactly one cycle, and at most one transaction is outstanding.
- D_wait=0 during the pulse cycle itself counts as the completion or beat.
- Reset mid-operation aborts the transaction. No partial line is marked valid.
- Counters:
  - Increment on LOOKUP→DONE (rhit), REFILL completion (rmiss), WRITE completion hit/miss (whit/wmiss).
  - Uncacheable accesses are not counted.
  - Counters saturate at 32'hFFFF_FFFF.

Decomposition:
- Shared package l1c_pkg:
  - cache_type_e encodings;
  - state enum (IDLE, LOOKUP, REFILL, UNC_RD, WRITE, DONE);
  - uncacheable window helper function.
- One sub-module, l1c_way_array: one way's data/tag/valid register array with byte-enable write port and flush input, instantiated twice.

Test Plan:
- Read 0x0000_0100 cold; memory returns 0xA0, 0xA1, 0xA2, 0xA3 -> D_rreq once with D_addr 0x100 and D_len 3. Re-read of 0x108 gives 0xA2 in 3 cycles; perf_rmiss=1, perf_rhit=1.
- Read 0x0000_0100, 0x0000_0500, 0x0000_0900 (same index, 3 tags) -> third read evicts the 0x100 line (LRU). Re-read of 0x500 hits; re-read of 0x100 issues D_rreq.
- After filling 0x100, BYTE store 0xEE to 0x101 -> D_wreq with D_type BYTE. Subsequent load of 0x100 returns the old word with byte1=0xEE and no memory read.
- Store WORD to uncached line 0x200 -> D_wreq only. Next load of 0x200 misses (perf_wmiss=1, no allocation).
- Load 0x1000_0004 -> D_rreq with D_len 0, exact address. Returned 0x1234_5678 appears on core_out; a repeat load issues D_rreq again.
- Fill a line, pulse flush in IDLE, re-read -> miss. Separately, assert rst during REFILL beat 2, then read the same address -> full refill, no stale hit.
